// File: rtl/cnn_pkg.sv
// Shared CNN-layer definitions: default bus widths, bias-fill FSM states and
// the bias word type.
package cnn_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  typedef logic [DEF_DATA_W-1:0] bias_word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_REQ,
    LOAD_WAIT,
    WRITE,
    FINISH
  } state_t;

endpackage

// File: rtl/bias_fill_engine_if.sv
// Bundles the bias fill engine's three interfaces: layer control, the bias
// burst read port and the pixel write port.
interface bias_fill_engine_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BURST  = 25,
  parameter int CNT_W  = 16
) ();

  logic                      start;
  logic [ADDR_W-1:0]         bias_base;
  logic [CNT_W-1:0]          num_biases;
  logic [ADDR_W-1:0]         out_base;
  logic [CNT_W-1:0]          out_size;
  logic                      busy;
  logic                      done;

  logic                      bias_rd_req;
  logic [ADDR_W-1:0]         bias_rd_addr;
  logic                      bias_rd_valid;
  logic [BURST*DATA_W-1:0]   bias_rd_data;

  logic                      wr_valid;
  logic [ADDR_W-1:0]         wr_addr;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_ready;

  modport slave (
    input  start, bias_base, num_biases, out_base, out_size,
    output busy, done,
    output bias_rd_req, bias_rd_addr,
    input  bias_rd_valid, bias_rd_data,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport master (
    output start, bias_base, num_biases, out_base, out_size,
    input  busy, done,
    input  bias_rd_req, bias_rd_addr,
    output bias_rd_valid, bias_rd_data,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );

endinterface

// File: rtl/bias_fill_engine_burst_buffer.sv
// Holds one burst of bias words, captured in a single cycle, with an indexed
// read port that returns zero for indices past the end of the burst.
module bias_burst_buffer
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BURST  = 25,
  parameter int IDX_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_capture,
  input  logic [BURST*DATA_W-1:0] i_data,
  input  logic [IDX_W-1:0]        i_idx,
  output logic [DATA_W-1:0]       o_word
);

  logic [DATA_W-1:0] r_words [BURST];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < BURST; k++) r_words[k] <= '0;
    end else if (i_capture) begin
      for (int k = 0; k < BURST; k++) r_words[k] <= i_data[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    o_word = '0;
    if (int'(i_idx) < BURST) o_word = r_words[i_idx];
  end

endmodule

// File: rtl/bias_fill_engine.sv
// Pre-fills each output feature map with its channel bias, loading biases in
// bursts and writing one pixel per cycle under write backpressure.
module bias_fill_engine
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BURST  = 25,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  bias_fill_engine_if.slave bus
);

  localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BURST - 1);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BURST_A  = ADDR_W'(BURST);

  state_t            r_state;
  logic [ADDR_W-1:0] r_biasPtr;
  logic [ADDR_W-1:0] r_wrPtr;
  logic [CNT_W-1:0]  r_numBiases;
  logic [CNT_W-1:0]  r_pixTotal;
  logic [CNT_W-1:0]  r_pixCnt;
  logic [CNT_W-1:0]  r_chCnt;
  logic [IDX_W-1:0]  r_burstIdx;
  logic              r_busy;
  logic              r_done;
  logic              r_rdReq;
  logic              r_wrValid;

  logic              w_capture;
  logic              w_chanDone;
  logic [CNT_W-1:0]  w_chNext;
  logic [DATA_W-1:0] w_word;

  assign w_capture  = (r_state == LOAD_WAIT) && bus.bias_rd_valid;
  assign w_chanDone = (r_pixCnt == (r_pixTotal - ONE_C));
  assign w_chNext   = r_chCnt + ONE_C;

  bias_burst_buffer #(
    .DATA_W (DATA_W),
    .BURST  (BURST),
    .IDX_W  (IDX_W)
  ) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .i_capture (w_capture),
    .i_data    (bus.bias_rd_data),
    .i_idx     (r_burstIdx),
    .o_word    (w_word)
  );

  // FINISH lasts one cycle when entered from WRITE (done already set on the
  // last accepted write) and two when entered straight from IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_biasPtr   <= '0;
      r_wrPtr     <= '0;
      r_numBiases <= '0;
      r_pixTotal  <= '0;
      r_pixCnt    <= '0;
      r_chCnt     <= '0;
      r_burstIdx  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rdReq     <= 1'b0;
      r_wrValid   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_biasPtr   <= bus.bias_base;
            r_wrPtr     <= bus.out_base;
            r_numBiases <= bus.num_biases;
            r_pixTotal  <= bus.out_size * bus.out_size;
            r_pixCnt    <= '0;
            r_chCnt     <= '0;
            r_burstIdx  <= '0;
            r_busy      <= 1'b1;
            if (bus.num_biases == '0 || bus.out_size == '0) begin
              r_state <= FINISH;
            end else begin
              r_state <= LOAD_REQ;
              r_rdReq <= 1'b1;
            end
          end
        end
        LOAD_REQ: begin
          r_rdReq <= 1'b0;
          r_state <= LOAD_WAIT;
        end
        LOAD_WAIT: begin
          if (bus.bias_rd_valid) begin
            r_burstIdx <= '0;
            r_wrValid  <= 1'b1;
            r_state    <= WRITE;
          end
        end
        WRITE: begin
          if (bus.wr_ready) begin
            r_wrPtr <= r_wrPtr + ONE_A;
            if (w_chanDone) begin
              r_pixCnt   <= '0;
              r_chCnt    <= w_chNext;
              r_burstIdx <= r_burstIdx + IDX_W'(1);
              if (w_chNext == r_numBiases) begin
                r_wrValid <= 1'b0;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
                r_state   <= FINISH;
              end else if (r_burstIdx == LAST_IDX) begin
                r_biasPtr <= r_biasPtr + BURST_A;
                r_wrValid <= 1'b0;
                r_rdReq   <= 1'b1;
                r_state   <= LOAD_REQ;
              end
            end else begin
              r_pixCnt <= r_pixCnt + ONE_C;
            end
          end
        end
        FINISH: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.bias_rd_req  = r_rdReq;
  assign bus.bias_rd_addr = r_biasPtr;
  assign bus.wr_valid     = r_wrValid;
  assign bus.wr_addr      = r_wrPtr;
  assign bus.wr_data      = w_word;

endmodule
